pc_fetch_unit: RTL and testbench

Parametrised program-counter and instruction-fetch sequencer for the next-generation CPU core. It replaces the free-running single-cycle PC with a state machine that loads a reset vector, fetches over a request/acknowledge handshake with variable-latency instruction memory, holds the instruction until the core commits, then computes the next PC. Supported next-PC sources are sequential, branch, jump and register. It adds halt/resume, misalignment fault detection and a retired-instruction counter. It sits between the instruction memory and the decode/control logic of the CPU top level.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/next_pc_calc.sv | 40 ++++
 rtl/pc_fetch_unit.sv | 97 +++++++++
 tb/tb_pc_fetch_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU core: next-PC select, fetch FSM states, PC step.
package cpu_pkg;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2,
      PC_JR     = 2'd3
   } pc_src_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_HALTED = 3'd3,
      S_FAULT  = 3'd4
   } state_e;

   localparam int PC_STEP = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, region jump, register jump.
import cpu_pkg::*;

module next_pc_calc #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] cur_pc,
   input  logic [1:0]        pc_src,
   input  logic [ADDR_W-1:0] ext_out,
   input  logic [25:0]       target,
   input  logic [ADDR_W-1:0] reg_target,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] pc_plus;
   logic [ADDR_W-1:0] jump_pc;

   assign pc_plus = cur_pc + ADDR_W'(PC_STEP);

   // Jumps keep the region bits above bit 27; at ADDR_W=28 there are none.
   generate
      if (ADDR_W > 28) begin : g_region
         assign jump_pc = {pc_plus[ADDR_W-1:28], target, 2'b00};
      end else begin : g_flat
         assign jump_pc = {target, 2'b00};
      end
   endgenerate

   always_comb begin
      next_pc = pc_plus;
      case (pc_src_e'(pc_src))
         PC_SEQ:    next_pc = pc_plus;
         PC_BRANCH: next_pc = pc_plus + (ext_out << 2);
         PC_JUMP:   next_pc = jump_pc;
         PC_JR:     next_pc = reg_target;
         default:   next_pc = pc_plus;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC and fetch sequencer: reset vector load, req/ack fetch, hold until commit,
// halt/resume, sticky misalignment fault and retired-instruction counter.
import cpu_pkg::*;

module pc_fetch_unit #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  initPC,
   output logic               imemReq,
   output logic [ADDR_W-1:0]  imemAddr,
   input  logic               imemAck,
   input  logic [INSTR_W-1:0] imemData,
   output logic [INSTR_W-1:0] instr,
   output logic               instrValid,
   input  logic               commit,
   input  logic [1:0]         pcSrc,
   input  logic [ADDR_W-1:0]  extOut,
   input  logic [25:0]        target,
   input  logic [ADDR_W-1:0]  regTarget,
   input  logic               halt,
   input  logic               resume,
   output logic [ADDR_W-1:0]  curPC,
   output logic               fault,
   output logic [CNT_W-1:0]   instret
);

   state_e            state;
   logic [ADDR_W-1:0] next_pc;

   next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
      .cur_pc     (curPC),
      .pc_src     (pcSrc),
      .ext_out    (extOut),
      .target     (target),
      .reg_target (regTarget),
      .next_pc    (next_pc)
   );

   assign imemAddr = curPC;

   // imemReq/instrValid/fault are registered alongside the state so they never glitch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         curPC      <= initPC;
         instr      <= '0;
         instrValid <= 1'b0;
         imemReq    <= 1'b0;
         fault      <= 1'b0;
         instret    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               state   <= S_FETCH;
               imemReq <= 1'b1;
            end
            S_FETCH: begin
               if (imemAck) begin
                  instr      <= imemData;
                  instrValid <= 1'b1;
                  imemReq    <= 1'b0;
                  state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (commit) begin
                  curPC      <= next_pc;
                  instret    <= instret + CNT_W'(1);
                  instrValid <= 1'b0;
                  if (next_pc[1:0] != 2'b00) begin
                     state <= S_FAULT;
                     fault <= 1'b1;
                  end else if (halt) begin
                     state <= S_HALTED;
                  end else begin
                     state   <= S_FETCH;
                     imemReq <= 1'b1;
                  end
               end
            end
            S_HALTED: begin
               if (resume) begin
                  state   <= S_FETCH;
                  imemReq <= 1'b1;
               end
            end
            S_FAULT: ;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: table of fetch/commit vectors plus halt, fault and reset sequences.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] initPC;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;
   logic [31:0] instr;
   logic        instrValid;
   logic        commit;
   logic [1:0]  pcSrc;
   logic [31:0] extOut;
   logic [25:0] target;
   logic [31:0] regTarget;
   logic        halt;
   logic        resume;
   logic [31:0] curPC;
   logic        fault;
   logic [31:0] instret;

   int n_chk  = 0;
   int n_fail = 0;

   pc_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .initPC(initPC),
      .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
      .instr(instr), .instrValid(instrValid), .commit(commit), .pcSrc(pcSrc),
      .extOut(extOut), .target(target), .regTarget(regTarget),
      .halt(halt), .resume(resume), .curPC(curPC), .fault(fault), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  src;
      logic [31:0] ext;
      logic [25:0] tgt;
      logic [31:0] rt;
      int          dly;
      logic        hlt;
      logic [31:0] nxt;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One fetch/commit round: wait for request, ack after v.dly wait states, commit.
   task automatic run(input vec_t v, input int exp_cnt);
      int n = 0;
      while (!imemReq && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", {63'd0, imemReq}, 64'd1);
      chk("req_addr", {32'd0, imemAddr}, {32'd0, v.addr});
      for (int i = 0; i < v.dly; i++) @(negedge clk);
      if (v.dly > 0) chk("req_hold", {31'd0, imemReq, imemAddr}, {31'd0, 1'b1, v.addr});
      imemAck  = 1'b1;
      imemData = v.data;
      @(negedge clk);
      imemAck  = 1'b0;
      imemData = 32'hdead_beef;
      chk("exec_valid", {62'd0, instrValid, imemReq}, 64'd2);
      chk("instr", {32'd0, instr}, {32'd0, v.data});
      commit    = 1'b1;
      pcSrc     = v.src;
      extOut    = v.ext;
      target    = v.tgt;
      regTarget = v.rt;
      halt      = v.hlt;
      @(negedge clk);
      commit = 1'b0;
      halt   = 1'b0;
      pcSrc  = 2'd0;
      chk("cur_pc", {32'd0, curPC}, {32'd0, v.nxt});
      chk("instret", {32'd0, instret}, 64'(exp_cnt));
      chk("valid_clr", {63'd0, instrValid}, 64'd0);
   endtask

   initial begin
      vec_t fv;
      bit   quiet;
      tbl[0]  = '{32'h18c,      32'h1111_0000, 2'd0, 32'h0,        26'h0,       32'h0,        0, 1'b0, 32'h190};
      tbl[1]  = '{32'h190,      32'h2222_0000, 2'd1, 32'hFFFFFFFE, 26'h0,       32'h0,        3, 1'b0, 32'h18c};
      tbl[2]  = '{32'h18c,      32'h3333_0000, 2'd2, 32'h0,        26'h0000063, 32'h0,        1, 1'b0, 32'h18c};
      tbl[3]  = '{32'h18c,      32'h4444_0000, 2'd3, 32'h0,        26'h0,       32'hFFFFFFF8, 0, 1'b0, 32'hFFFFFFF8};
      tbl[4]  = '{32'hFFFFFFF8, 32'h5555_0000, 2'd0, 32'h0,        26'h0,       32'h0,        2, 1'b0, 32'hFFFFFFFC};
      tbl[5]  = '{32'hFFFFFFFC, 32'h6666_0000, 2'd0, 32'h0,        26'h0,       32'h0,        0, 1'b0, 32'h0};
      tbl[6]  = '{32'h0,        32'h7777_0000, 2'd3, 32'h0,        26'h0,       32'h40000000, 0, 1'b0, 32'h40000000};
      tbl[7]  = '{32'h40000000, 32'h8888_0000, 2'd2, 32'h0,        26'h3FFFFFF, 32'h0,        1, 1'b0, 32'h4FFFFFFC};
      tbl[8]  = '{32'h4FFFFFFC, 32'h9999_0000, 2'd1, 32'h10,       26'h0,       32'h0,        0, 1'b0, 32'h50000040};
      tbl[9]  = '{32'h50000040, 32'haaaa_0000, 2'd3, 32'h0,        26'h0,       32'h200,      0, 1'b0, 32'h200};
      tbl[10] = '{32'h200,      32'hbbbb_0000, 2'd0, 32'h0,        26'h0,       32'h0,        0, 1'b1, 32'h204};

      reset = 1'b0; initPC = 32'h18c; imemAck = 1'b0; imemData = '0; commit = 1'b0;
      pcSrc = 2'd0; extOut = '0; target = '0; regTarget = '0; halt = 1'b0; resume = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_pc", {32'd0, curPC}, 64'h18c);
      chk("rst_flags", {61'd0, imemReq, instrValid, fault}, 64'd0);
      chk("rst_cnt_instr", {instret, instr}, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("first_req", {31'd0, imemReq, imemAddr}, {31'd0, 1'b1, 32'h18c});

      for (int i = 0; i < 11; i++) run(tbl[i], i + 1);

      // Halted: stray ack/commit must not move anything.
      quiet = 1'b1;
      imemAck = 1'b1; commit = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imemReq) quiet = 1'b0;
      end
      imemAck = 1'b0; commit = 1'b0;
      chk("halt_quiet", {63'd0, quiet}, 64'd1);
      chk("halt_state", {curPC, instret}, {32'h204, 32'd11});
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      chk("resume_req", {31'd0, imemReq, imemAddr}, {31'd0, 1'b1, 32'h204});

      // Misaligned JR with halt: fault wins over halt.
      fv = '{32'h204, 32'hcccc_0000, 2'd3, 32'h0, 26'h0, 32'h202, 0, 1'b1, 32'h202};
      run(fv, 12);
      chk("fault_set", {62'd0, fault, imemReq}, 64'd2);
      commit = 1'b1; resume = 1'b1; imemAck = 1'b1;
      repeat (3) @(negedge clk);
      commit = 1'b0; resume = 1'b0; imemAck = 1'b0;
      @(negedge clk);
      chk("fault_sticky", {29'd0, fault, imemReq, instrValid, curPC}, {29'd0, 3'b100, 32'h202});
      chk("fault_cnt", {32'd0, instret}, 64'd12);

      initPC = 32'h300;
      reset  = 1'b0;
      #1;
      chk("fault_clr", {31'd0, fault, curPC}, {31'd0, 1'b0, 32'h300});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      fv = '{32'h300, 32'hdddd_0000, 2'd0, 32'h0, 26'h0, 32'h0, 0, 1'b0, 32'h304};
      run(fv, 1);

      // Asynchronous reset while a request is outstanding.
      chk("mid_req", {31'd0, imemReq, imemAddr}, {31'd0, 1'b1, 32'h304});
      initPC = 32'h400;
      #2 reset = 1'b0;
      #1;
      chk("async_rst", {30'd0, imemReq, instrValid, curPC}, {32'd0, 32'h400});
      chk("async_cnt", {32'd0, instret}, 64'd0);
      imemAck = 1'b1; imemData = 32'h5a5a_5a5a;
      repeat (2) @(negedge clk);
      imemAck = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      chk("post_rst", {30'd0, imemReq, instrValid, imemAddr}, {30'd0, 2'b10, 32'h400});
      chk("post_rst_instr", {32'd0, instr}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
